// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage register: FSM state encoding and occupancy constants.
package pipe_pkg;

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_EMPTY = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

  // Occupancy reported for each state.
  function automatic logic [CNT_W-1:0] state_count(input state_e s);
    logic [CNT_W-1:0] c;
    case (s)
      ST_FULL: c = CNT_ONE;
      ST_SKID: c = CNT_TWO;
      default: c = CNT_EMPTY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with optional skid slot, synchronous flush
// and occupancy count; sits between CPU datapath stages.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count
);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid;

  logic w_in_ready;
  logic w_accept;
  logic w_pop;
  logic w_load_in;
  logic w_load_skid;
  logic w_load_from_skid;

  // With a skid slot in_ready is a flop; without it, it looks through to out_ready.
  assign w_in_ready = (SKID != 0) ? r_in_ready
                                  : (~reset & (~out_valid | out_ready));
  assign in_ready   = w_in_ready;
  assign w_accept   = in_valid & w_in_ready;
  assign w_pop      = out_valid & out_ready;
  assign out_data   = r_out_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != ST_SKID);
    end
  end

  // Flush squashes everything, including a same-cycle accept.
  always_comb begin
    w_state_next     = r_state;
    w_load_in        = 1'b0;
    w_load_skid      = 1'b0;
    w_load_from_skid = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_FULL;
            w_load_in    = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_accept && w_pop) begin
            w_load_in = 1'b1;
          end else if (w_accept) begin
            w_state_next = ST_SKID;
            w_load_skid  = 1'b1;
          end else if (w_pop) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_pop) begin
            w_state_next     = ST_FULL;
            w_load_from_skid = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (r_state != ST_EMPTY);
    count     = state_count(r_state);
  end

  // Payload storage moves only on accept or pop; flush leaves it in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data <= RESET_VAL;
      r_skid     <= '0;
    end else begin
      if (w_load_in) begin
        r_out_data <= in_data;
      end else if (w_load_from_skid) begin
        r_out_data <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

`ifdef STAGE_TRACE
  always @(posedge clk) begin
    if (!reset && !flush && (w_accept || w_pop)) begin
      $display("[%0t] stage count=%0d in_data=%h out_data=%h acc=%0b pop=%0b",
               $time, count, in_data, out_data, w_accept, w_pop);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table on the skid variant, queue-based
// reference model for both skid and no-skid variants, and random traffic.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        o1_in_ready, o1_valid;
  logic [31:0] o1_data;
  logic [1:0]  o1_count;
  logic        o0_in_ready, o0_valid;
  logic [31:0] o0_data;
  logic [1:0]  o0_count;

  int n_chk;
  int n_fail;

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .RESET_VAL(32'h0)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(o1_in_ready),
    .out_valid(o1_valid), .out_data(o1_data), .out_ready(out_ready),
    .count(o1_count)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(0), .RESET_VAL(32'h0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(o0_in_ready),
    .out_valid(o0_valid), .out_data(o0_data), .out_ready(out_ready),
    .count(o0_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        chk;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  cnt;
    logic        ir;
  } vec_t;

  // Reference model: each stage is a FIFO of capacity 1 or 2 plus the last head value.
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [31:0] h1, h0;
  logic        m_ir1;
  logic        m_known;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic [31:0] d, input logic ordy, input logic c,
                              input logic ov, input logic [31:0] od,
                              input logic [1:0] cnt, input logic ir);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.chk = c; v.ov = ov; v.od = od; v.cnt = cnt; v.ir = ir;
    return v;
  endfunction

  task automatic step(input vec_t v);
    logic exp_ir0;
    logic acc, pop;
    reset = v.rst; flush = v.fl; in_valid = v.iv; in_data = v.d; out_ready = v.ordy;
    #1;
    exp_ir0 = !v.rst && ((q0.size() == 0) || v.ordy);
    if (m_known) begin
      chk("m1_valid", 32'(o1_valid), 32'(q1.size() != 0));
      chk("m1_data",  o1_data, h1);
      chk("m1_count", 32'(o1_count), 32'(q1.size()));
      chk("m1_ready", 32'(o1_in_ready), 32'(m_ir1));
      chk("m0_valid", 32'(o0_valid), 32'(q0.size() != 0));
      chk("m0_data",  o0_data, h0);
      chk("m0_count", 32'(o0_count), 32'(q0.size()));
      chk("m0_ready", 32'(o0_in_ready), 32'(exp_ir0));
    end
    if (v.chk) begin
      chk("tbl_valid", 32'(o1_valid), 32'(v.ov));
      chk("tbl_data",  o1_data, v.od);
      chk("tbl_count", 32'(o1_count), 32'(v.cnt));
      chk("tbl_ready", 32'(o1_in_ready), 32'(v.ir));
    end
    if (v.rst) begin
      q1.delete(); q0.delete();
      h1 = 32'h0; h0 = 32'h0;
      m_known = 1'b1;
      m_ir1 = 1'b0;
    end else if (v.fl) begin
      q1.delete(); q0.delete();
      m_ir1 = 1'b1;
    end else begin
      acc = v.iv && m_ir1;
      pop = (q1.size() != 0) && v.ordy;
      if (pop) void'(q1.pop_front());
      if (acc) q1.push_back(v.d);
      if (q1.size() != 0) h1 = q1[0];
      m_ir1 = (q1.size() < 2);
      acc = v.iv && exp_ir0;
      pop = (q0.size() != 0) && v.ordy;
      if (pop) void'(q0.pop_front());
      if (acc) q0.push_back(v.d);
      if (q0.size() != 0) h0 = q0[0];
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    n_chk = 0; n_fail = 0;
    m_known = 1'b0; m_ir1 = 1'b0; h1 = '0; h0 = '0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    tbl.push_back(mk(1,0,0,32'h0 ,0, 0, 0,32'h0 ,0,0));
    tbl.push_back(mk(1,0,0,32'h0 ,0, 1, 0,32'h0 ,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 1, 0,32'h0 ,0,0));
    tbl.push_back(mk(0,0,1,32'hA0,0, 1, 0,32'h0 ,0,1));
    tbl.push_back(mk(0,0,1,32'hA1,0, 1, 1,32'hA0,1,1));
    tbl.push_back(mk(0,0,1,32'hA2,0, 1, 1,32'hA0,2,0));
    tbl.push_back(mk(0,0,1,32'hA2,1, 1, 1,32'hA0,2,0));
    tbl.push_back(mk(0,0,1,32'hA2,1, 1, 1,32'hA1,1,1));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1, 1,32'hA2,1,1));
    tbl.push_back(mk(0,0,1,32'hB0,0, 1, 0,32'hA2,0,1));
    tbl.push_back(mk(0,0,1,32'hB1,0, 1, 1,32'hB0,1,1));
    tbl.push_back(mk(0,1,1,32'hB2,0, 1, 1,32'hB0,2,0));
    tbl.push_back(mk(0,0,1,32'hB3,0, 1, 0,32'hB0,0,1));
    tbl.push_back(mk(0,1,1,32'hB4,0, 1, 1,32'hB3,1,1));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 1, 0,32'hB3,0,1));
    tbl.push_back(mk(0,0,1,32'hE0,0, 1, 0,32'hB3,0,1));
    tbl.push_back(mk(0,0,1,32'hE1,0, 1, 1,32'hE0,1,1));
    tbl.push_back(mk(1,0,1,32'hE2,1, 1, 1,32'hE0,2,0));
    tbl.push_back(mk(0,0,1,32'hC0,1, 1, 0,32'h0 ,0,0));
    tbl.push_back(mk(0,0,1,32'hC0,1, 1, 0,32'h0 ,0,1));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1, 1,32'hC0,1,1));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1, 0,32'hC0,0,1));
    for (int k = 0; k < 8; k++) begin
      tbl.push_back(mk(0,0,1,32'h11111101 + 32'(k),1, 1,
                       (k > 0), (k == 0) ? 32'hC0 : 32'h11111100 + 32'(k),
                       (k > 0) ? 2'd1 : 2'd0, 1));
    end
    tbl.push_back(mk(0,0,0,32'h0,1, 1, 1,32'h11111108,1,1));
    tbl.push_back(mk(0,0,0,32'h0,1, 1, 0,32'h11111108,0,1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Same-cycle pop and accept on the no-skid variant.
    step(mk(1,0,0,32'h0 ,0, 0, 0,0,0,0));
    step(mk(0,0,0,32'h0 ,0, 0, 0,0,0,0));
    step(mk(0,0,1,32'hD0,0, 0, 0,0,0,0));
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hD1; out_ready = 1'b1;
    #1;
    chk("d_ready_comb", 32'(o0_in_ready), 32'h1);
    chk("d_head", o0_data, 32'hD0);
    step(mk(0,0,1,32'hD1,1, 0, 0,0,0,0));
    chk("d_next_data", o0_data, 32'hD1);
    chk("d_next_count", 32'(o0_count), 32'h1);
    chk("d_next_valid", 32'(o0_valid), 32'h1);
    step(mk(0,0,0,32'h0,1, 0, 0,0,0,0));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
              0, 0, 0, 0, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
